// File: rtl/truth_table_sequencer.sv
// Sweeps {P,Q,R} through all 8 vectors, holds each for SETTLE+1 cycles, and captures F into table_out.
// Optional macro TT_COMPARE_EN adds the golden-table comparison (match / first_err).
module truth_table_sequencer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       f_in,
    output logic       p_out,
    output logic       q_out,
    output logic       r_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       match,
    output logic [2:0] first_err,
    output logic [1:0] o_dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    logic [1:0] r_state;
    logic [2:0] r_idx;
    logic [3:0] r_cnt;
    logic [7:0] r_table;

    logic       w_start_ok;
    logic       w_capture;
    logic       w_last;
    logic [7:0] w_next_table;

    // abort wins over a capture that falls in the same cycle
    assign w_start_ok = (r_state == ST_IDLE) && start && !abort;
    assign w_capture  = (r_state == ST_RUN) && !abort && (r_cnt == SETTLE_C);
    assign w_last     = w_capture && (r_idx == 3'd7);

    always_comb begin
        w_next_table        = r_table;
        w_next_table[r_idx] = f_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 3'd0;
            r_cnt   <= 4'd0;
            r_table <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state <= ST_RUN;
                        r_idx   <= 3'd0;
                        r_cnt   <= 4'd0;
                        r_table <= 8'h00;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_idx   <= 3'd0;
                        r_cnt   <= 4'd0;
                    end else if (w_capture) begin
                        r_table <= w_next_table;
                        r_cnt   <= 4'd0;
                        r_idx   <= r_idx + 3'd1;
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TT_COMPARE_EN
    logic       r_match;
    logic [2:0] r_first_err;
    logic [7:0] w_diff;
    logic [2:0] w_first_err;

    assign w_diff = w_next_table ^ expected;

    // scan downwards so the lowest differing index is the one that sticks
    always_comb begin
        w_first_err = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_diff[i]) begin
                w_first_err = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match     <= 1'b0;
            r_first_err <= 3'd0;
        end else if (w_start_ok) begin
            r_match     <= 1'b0;
            r_first_err <= 3'd0;
        end else if (w_last) begin
            r_match     <= (w_diff == 8'h00);
            r_first_err <= w_first_err;
        end
    end

    assign match     = r_match;
    assign first_err = r_first_err;
`else
    logic w_unused_expected;
    assign w_unused_expected = ^expected;
    assign match     = 1'b0;
    assign first_err = 3'd0;
`endif

    assign {p_out, q_out, r_out} = r_idx;
    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign table_out   = r_table;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: two instances (SETTLE=2 and SETTLE=0) share stimulus and are
// checked against an elapsed-time reference model plus a queue of expected sweep results.
module tb_truth_table_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_v = 1'b0;
  logic       abort_v = 1'b0;
  logic [7:0] exp_v = 8'h00;
  logic [7:0] func_tt = 8'h00;

  logic       p_w[2], q_w[2], r_w[2], f_w[2];
  logic       busy_w[2], done_w[2], match_w[2];
  logic [7:0] tbl_w[2];
  logic [2:0] fe_w[2];
  logic [1:0] dbg_w[2];

  int settle_of[2] = '{2, 0};

  // reference model state: elapsed edges since the accepted start
  bit         m_active[2];
  bit         m_done[2];
  int         m_t[2];
  logic [7:0] m_table[2];
  logic       m_match[2];
  logic [2:0] m_ferr[2];

  // {done_cycle[31:0], table[7:0], match, first_err[2:0]}
  logic [43:0] exp_q0[$];
  logic [43:0] exp_q1[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign f_w[0] = func_tt[{p_w[0], q_w[0], r_w[0]}];
  assign f_w[1] = func_tt[{p_w[1], q_w[1], r_w[1]}];

  truth_table_sequencer #(.SETTLE(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v), .abort(abort_v), .expected(exp_v),
    .f_in(f_w[0]), .p_out(p_w[0]), .q_out(q_w[0]), .r_out(r_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .table_out(tbl_w[0]), .match(match_w[0]), .first_err(fe_w[0]),
    .o_dbg_state(dbg_w[0])
  );

  truth_table_sequencer #(.SETTLE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v), .abort(abort_v), .expected(exp_v),
    .f_in(f_w[1]), .p_out(p_w[1]), .q_out(q_w[1]), .r_out(r_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .table_out(tbl_w[1]), .match(match_w[1]), .first_err(fe_w[1]),
    .o_dbg_state(dbg_w[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [2:0] lowest_diff(input logic [7:0] a, input logic [7:0] b);
    for (int k = 0; k < 8; k++) begin
      if (a[k] != b[k]) return 3'(k);
    end
    return 3'd0;
  endfunction

  task automatic push_exp(input int i, input logic [43:0] e);
    if (i == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  task automatic drop_last(input int i);
    if (i == 0 && exp_q0.size() > 0) void'(exp_q0.pop_back());
    if (i == 1 && exp_q1.size() > 0) void'(exp_q1.pop_back());
  endtask

  function automatic logic [2:0] model_idx(input int i);
    if (!m_active[i]) return 3'd0;
    return 3'(m_t[i] / (settle_of[i] + 1));
  endfunction

  // one rising edge of the reference model, using the inputs the driver applied
  task automatic model_update();
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int per;
      per = settle_of[i] + 1;
      if (m_done[i]) begin
        m_done[i] = 1'b0;
      end else if (m_active[i]) begin
        if (abort_v) begin
          m_active[i] = 1'b0;
          drop_last(i);
        end else begin
          m_t[i]++;
          if (m_t[i] % per == 0) begin
            int k;
            k = m_t[i] / per - 1;
            m_table[i][k] = func_tt[k];
            if (k == 7) begin
              m_active[i] = 1'b0;
              m_done[i]   = 1'b1;
`ifdef TT_COMPARE_EN
              m_match[i] = (m_table[i] == exp_v);
              m_ferr[i]  = lowest_diff(m_table[i], exp_v);
`endif
            end
          end
        end
      end else if (start_v && !abort_v) begin
        logic       pm;
        logic [2:0] pf;
        m_active[i] = 1'b1;
        m_t[i]      = 0;
        m_table[i]  = 8'h00;
        pm = 1'b0;
        pf = 3'd0;
`ifdef TT_COMPARE_EN
        m_match[i] = 1'b0;
        m_ferr[i]  = 3'd0;
        pm = (func_tt == exp_v);
        pf = lowest_diff(func_tt, exp_v);
`endif
        push_exp(i, {32'(cyc + 8 * per), func_tt, pm, pf});
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0;
      m_done[i]   = 1'b0;
      m_t[i]      = 0;
      m_table[i]  = 8'h00;
      m_match[i]  = 1'b0;
      m_ferr[i]   = 3'd0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_pqr%0d", tag, i), {p_w[i], q_w[i], r_w[i]}, 0);
      chk($sformatf("%s_busy%0d", tag, i), busy_w[i], 0);
      chk($sformatf("%s_done%0d", tag, i), done_w[i], 0);
      chk($sformatf("%s_table%0d", tag, i), tbl_w[i], 0);
      chk($sformatf("%s_match%0d", tag, i), match_w[i], 0);
      chk($sformatf("%s_ferr%0d", tag, i), fe_w[i], 0);
    end
  endtask

  // driver: called and returns at a falling edge
  task automatic step(input logic st, input logic ab);
    start_v = st;
    abort_v = ab;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic reset_mid_cycle();
    start_v = 1'b0;
    abort_v = 1'b0;
    @(posedge clk);
    model_update();
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // monitor: cycle-level comparison plus scoreboard pop on every done pulse
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy%0d", i), busy_w[i], m_active[i]);
        chk($sformatf("done%0d", i), done_w[i], m_done[i]);
        chk($sformatf("pqr%0d", i), {p_w[i], q_w[i], r_w[i]}, model_idx(i));
        chk($sformatf("table%0d", i), tbl_w[i], m_table[i]);
        chk($sformatf("match%0d", i), match_w[i], m_match[i]);
        chk($sformatf("first_err%0d", i), fe_w[i], m_ferr[i]);
        if (done_w[i]) begin
          logic [43:0] e;
          int qs;
          qs = (i == 0) ? exp_q0.size() : exp_q1.size();
          if (qs == 0) begin
            chk($sformatf("unexpected_done%0d", i), 1, 0);
          end else begin
            e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("done_cycle%0d", i), 64'(cyc), 64'(e[43:12]));
            chk($sformatf("sb_table%0d", i), tbl_w[i], e[11:4]);
            chk($sformatf("sb_match%0d", i), match_w[i], e[3]);
            chk($sformatf("sb_first_err%0d", i), fe_w[i], e[2:0]);
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    #2;
    check_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // (P&Q)|R against a matching and a mismatching golden table
    func_tt = 8'hEA;
    exp_v   = 8'hEA;
    step(1'b1, 1'b0);
    for (int n = 0; n < 30; n++) step(1'b0, 1'b0);
    exp_v = 8'hEB;
    step(1'b1, 1'b0);
    for (int n = 0; n < 30; n++) step(1'b0, 1'b0);

    // abort ten cycles into a sweep keeps the partial capture
    exp_v = 8'hEA;
    step(1'b1, 1'b0);
    for (int n = 0; n < 9; n++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("abort_busy", busy_w[0], 0);
    chk("abort_table", tbl_w[0], 8'h02);
    chk("abort_pqr", {p_w[0], q_w[0], r_w[0]}, 0);
    for (int n = 0; n < 5; n++) step(1'b0, 1'b0);

    // start and abort together in idle is ignored; abort in idle is harmless
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("start_abort_idle", busy_w[0], 0);

    // start held high: back-to-back sweeps, never overlapping
    for (int n = 0; n < 80; n++) step(1'b1, 1'b0);
    for (int n = 0; n < 30; n++) step(1'b0, 1'b0);

    // reset in the middle of a sweep
    step(1'b1, 1'b0);
    for (int n = 0; n < 5; n++) step(1'b0, 1'b0);
    reset_mid_cycle();
    for (int n = 0; n < 30; n++) step(1'b0, 1'b0);

    // P^Q^R: the SETTLE=0 instance finishes 8 cycles after start
    func_tt = 8'h96;
    exp_v   = 8'h96;
    step(1'b1, 1'b0);
    for (int n = 0; n < 30; n++) step(1'b0, 1'b0);
    chk("parity_table1", tbl_w[1], 8'h96);
    chk("parity_table0", tbl_w[0], 8'h96);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if (!m_active[0] && !m_done[0] && !m_active[1] && !m_done[1] && $urandom_range(0, 3) == 0) begin
        func_tt = 8'($urandom);
        exp_v   = ($urandom_range(0, 1) == 0) ? func_tt : 8'($urandom);
      end
      step($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
    end

    // drain outstanding sweeps within a bounded budget
    for (int n = 0; n < 60 && (exp_q0.size() > 0 || exp_q1.size() > 0); n++) begin
      step(1'b0, 1'b0);
    end
    chk("queue0_empty", exp_q0.size(), 0);
    chk("queue1_empty", exp_q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
